dynamic_seg_n: RTL

Parametrised multiplexed 7-segment display driver. It generalises the 4-digit scanner to DIGITS digits with a configurable refresh period. It adds an internal sequential binary-to-BCD converter with a valid/busy handshake, per-digit blinking, and over-range saturation. It sits between the measurement/control logic and the board's digit-select and segment pins, and shows either the converted value or a latched student ID.

---
 rtl/dynamic_seg_n.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dynamic_seg_n.sv
// dynamic_seg_n: multiplexed DIGITS-digit 7-segment driver.
// A sequential double-dabble converter turns the binary input into BCD behind a
// valid/busy handshake; values above 10^DIGITS-1 saturate to all nines. The scan
// shows either the BCD value or an ID latched after reset, with per-digit blink.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros in data mode).
module dynamic_seg_n #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned CNT_MAX     = 99_999,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [DATA_W-1:0]   data,
    input  logic                data_vld,
    output logic                busy,
    input  logic [DIGITS-1:0]   point,
    input  logic [DIGITS-1:0]   blink,
    input  logic                seg_en,
    input  logic [4*DIGITS-1:0] data_ID,
    output logic [DIGITS-1:0]   sel,
    output logic [7:0]          seg
);

    localparam int unsigned CntW  = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned IdxW  = $clog2(DIGITS);
    localparam int unsigned BcntW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned ShW   = $clog2(DATA_W + 1);
    localparam int unsigned BcdW  = 4 * DIGITS;

    function automatic longint unsigned max_value(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < int'(n); i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint unsigned MaxVal = max_value(DIGITS);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    // Refresh tick counter
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick;

    assign tick = (cnt_q == CntW'(CNT_MAX));

    // Next tick count: wrap at CNT_MAX
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    // Tick counter register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ID is captured once, on the first edge after reset release
    logic            id_vld_q;
    logic [BcdW-1:0] id_q;

    // ID capture
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            id_q     <= '0;
            id_vld_q <= 1'b0;
        end else if (!id_vld_q) begin
            id_q     <= data_ID;
            id_vld_q <= 1'b1;
        end
    end

    // Converter state
    state_e          state_q;
    logic            busy_q;
    logic            over_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BcdW-1:0] work_q;
    logic [BcdW-1:0] bcd_q;
    logic [ShW-1:0]  sh_cnt_q;
    logic [BcdW-1:0] work_adj;
    logic [BcdW-1:0] work_d;

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next MSB.
    // Only DIGITS nibbles are kept; any value that would overflow them is
    // over-range and gets replaced by all nines at DONE.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        work_d = {work_adj[BcdW-2:0], shreg_q[DATA_W-1]};
    end

    // Converter FSM with registered busy and BCD result
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
            shreg_q  <= '0;
            work_q   <= '0;
            bcd_q    <= '0;
            sh_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (data_vld) begin
                        shreg_q  <= data;
                        work_q   <= '0;
                        sh_cnt_q <= '0;
                        over_q   <= (64'(data) > MaxVal);
                        busy_q   <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    work_q  <= work_d;
                    shreg_q <= shreg_q << 1;
                    if (sh_cnt_q == ShW'(DATA_W - 1)) begin
                        state_q <= StDone;
                    end else begin
                        sh_cnt_q <= sh_cnt_q + ShW'(1);
                    end
                end
                StDone: begin
                    bcd_q   <= over_q ? {DIGITS{4'h9}} : work_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // Leading-zero mask: digit i is blank when it and everything above it is zero
    logic [DIGITS-1:0] lz;
`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the most significant digit down; digit 0 is never masked
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz         = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd_q[4*i +: 4] == 4'h0);
            lz[i]      = zero_above;
        end
    end
`else
    assign lz = '0;
`endif

    // Scan state
    logic [IdxW-1:0]   idx_q;
    logic [BcntW-1:0]  bcnt_q;
    logic              phase_q;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        dig_nib;
    logic              dig_dp;
    logic              dig_blink;
    logic              dig_lz;

    // Select and segment pattern for the digit currently indexed
    always_comb begin
        dig_nib   = '0;
        dig_dp    = 1'b0;
        dig_blink = 1'b0;
        dig_lz    = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IdxW'(i) == idx_q) begin
                dig_nib   = seg_en ? bcd_q[4*i +: 4] : id_q[4*i +: 4];
                dig_dp    = point[i];
                dig_blink = blink[i];
                dig_lz    = lz[i];
            end
        end
        seg_d = {dig_dp, seg_decode(dig_nib)};
        if (seg_en && dig_lz) begin
            seg_d[6:0] = '0;
        end
        if (phase_q && dig_blink) begin
            seg_d = '0;
        end
        sel_d = DIGITS'(1) << idx_q;
    end

    // On each tick register sel/seg together and advance digit index and blink phase
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q   <= '0;
            seg_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            sel_q <= sel_d;
            seg_q <= seg_d;
            idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
            if (bcnt_q == BcntW'(BLINK_TICKS - 1)) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + BcntW'(1);
            end
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule
